uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer and issue controller placed directly upstream of the UART transmitter. Accepts bytes from the system side into a synchronous FIFO and presents them one at a time on the transmitter's `tx_data`/`tx_data_valid` interface. It issues a single-cycle valid strobe only when the transmitter reports ready, then waits for the transmitter's end-of-frame `tx_ack` before issuing the next byte.

## Interface
- `ADDR_W`, 4: FIFO address width; depth = 2^ADDR_W entries.
- `ACK_TIMEOUT`, 65535: watchdog limit in clocks, used only with `UART_TX_FIFO_WDOG_EN`.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_data` in 8: byte to enqueue.
- `wr_en` in 1: enqueue strobe; sampled every clock.
- `full` out 1: FIFO holds 2^ADDR_W bytes (combinational from pointers).
- `empty` out 1: FIFO holds 0 bytes (combinational from pointers).
- `level` out ADDR_W+1: current occupancy, 0..2^ADDR_W.
- `overflow` out 1: one-cycle pulse when `wr_en` is sampled while `full`.
- `tx_data` out 8: byte presented to the transmitter (registered).
- `tx_data_valid` out 1: one-cycle issue strobe to the transmitter (registered).
- `tx_data_ready` in 1: transmitter idle and able to accept.
- `tx_ack` in 1: transmitter one-cycle pulse at the end of the stop bit.
- `timeout_err` out 1: one-cycle pulse on watchdog expiry; constant 0 when the watchdog is compiled out.

## Operation
- **FIFO**
  - wr_ptr and rd_ptr are ADDR_W+1 bits with an extra wrap bit. full = addresses equal and wrap bits differ. empty = pointers equal.
  - A write occurs when `wr_en && !full`. A write while full is dropped, and `overflow` pulses on the next cycle.
  - `full` is evaluated before the same-cycle pop, so a write while full is dropped even if a pop occurs in that cycle.
  - A pop occurs only in S_LOAD. A simultaneous write and pop leaves `level` unchanged.
  - Pointers wrap modulo 2^(ADDR_W+1).
- **Issue FSM**
  - S_IDLE: if `!empty`, go to S_LOAD.
  - S_LOAD: `tx_data <= mem[rd_ptr]`, increment rd_ptr, go to S_REQ.
  - S_REQ: if `tx_data_ready`, set `tx_data_valid <= 1` and go to S_WAIT. Otherwise hold.
  - S_WAIT: `tx_data_valid <= 0`. On `tx_ack`, go to S_IDLE.
  - `tx_data_valid` is never high for more than one cycle per byte.
  - `tx_data` is held stable from S_LOAD until the next S_LOAD.
- `tx_ack` seen outside S_WAIT is ignored.
- **Reset** (synchronous) values:
  - state S_IDLE, pointers 0, counter 0.
  - `tx_data` 8'h00, `tx_data_valid` 0, `overflow` 0, `timeout_err` 0.
  - `empty` 1, `full` 0, `level` 0.
  - FIFO memory is not cleared.
- Reset mid-frame discards all queued bytes and the byte in flight. The top level must reset the transmitter in the same cycle.

## Timing
- `wr_en` sampled at edge N into an empty FIFO, with the FSM in S_IDLE and `tx_data_ready` high:
  - `empty` falls after edge N.
  - S_LOAD after edge N+1.
  - `tx_data` valid after edge N+2.
  - `tx_data_valid` high for the single cycle after edge N+3.
- `tx_ack` sampled at edge M: S_IDLE after edge M. If the FIFO is non-empty, the next `tx_data_valid` is no earlier than after edge M+3, and only once `tx_data_ready` is high.
- Back-to-back bytes carry a fixed overhead of 3 clocks plus ready latency between frames. This overhead is negligible against the frame time.
- `level`, `full` and `empty` update the cycle after the write or pop edge.

## Configuration
- Macro: `UART_TX_FIFO_WDOG_EN`.
- **Defined:**
  - A 16-bit counter clears on entry to S_WAIT and increments each clock in S_WAIT.
  - If it reaches `ACK_TIMEOUT-1` without `tx_ack`, `timeout_err` pulses for one cycle and the FSM returns to S_IDLE.
  - The in-flight byte is dropped and is not retried.
  - `tx_ack` in the expiry cycle takes priority: normal completion, no error.
- **Undefined:** no counter; S_WAIT waits indefinitely for `tx_ack`; `timeout_err` is tied to 0.

## Test plan
- **Reset:** assert `rst` 2 clocks mid-operation with level=5 -> next cycle `empty`=1, `level`=0, `tx_data_valid`=0, `tx_data`=8'h00.
- **Single byte:** write 8'hA5 with ready=1 -> `tx_data`=8'hA5, then a `tx_data_valid` pulse exactly 3 clocks after the write edge. No second pulse until `tx_ack`.
- **Fill, overflow and order (ADDR_W=4):** write 17 bytes 8'h00..8'h10 with ready held 0 -> `full`=1 after the 16th, `overflow` pulses once, 8'h10 is dropped. Released bytes appear in order 8'h00..8'h0F.
- **Simultaneous write and pop:** write in the S_LOAD cycle with level=3 -> level stays 3; the pointer wraps correctly across 20 bytes.
- **Ready gating:** hold `tx_data_ready`=0 for 50 clocks in S_REQ -> no valid. Ready high -> valid on the next cycle, exactly one cycle wide.
- **Watchdog (macro defined, ACK_TIMEOUT=100):** withhold `tx_ack` -> `timeout_err` pulses 100 clocks after entering S_WAIT and the next byte issues. Same stimulus with the macro undefined -> stays in S_WAIT, `timeout_err`=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that issues one byte at a time to a UART transmitter
//   clk, rst               : rising-edge clock, synchronous active-high reset
//   wr_data, wr_en         : system-side enqueue port
//   full, empty, level     : FIFO status, combinational from the pointers
//   overflow               : one-cycle pulse after a write is dropped because the FIFO was full
//   tx_data, tx_data_valid : registered byte and one-cycle issue strobe to the transmitter
//   tx_data_ready, tx_ack  : transmitter idle flag and end-of-frame pulse
//   timeout_err            : one-cycle pulse when the ack watchdog expires
// The ack watchdog is compiled in by defining UART_TX_FIFO_WDOG_EN; otherwise timeout_err is 0.
module uart_tx_fifo #(
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [7:0]        tx_data,
  output logic              tx_data_valid,
  input  logic              tx_data_ready,
  input  logic              tx_ack,
  output logic              timeout_err
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT} state_t;
  state_t state, state_n;
  logic [7:0] mem [2**ADDR_W];
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic wr, expire;
  // The watchdog counter is 16 bits wide, so the limit must fit in it.
  if (ACK_TIMEOUT < 2 || ACK_TIMEOUT > 65536) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be within 2..65536");
  end
  assign full  = wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0] && wr_ptr[ADDR_W] != rd_ptr[ADDR_W];
  assign empty = wr_ptr == rd_ptr;
  assign level = wr_ptr - rd_ptr;
  // full is taken before any same-cycle pop, so a write while full is always dropped.
  assign wr    = wr_en && !full;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = empty ? S_IDLE : S_LOAD;
      S_LOAD:  state_n = S_REQ;
      S_REQ:   state_n = tx_data_ready ? S_WAIT : S_REQ;
      default: state_n = (tx_ack || expire) ? S_IDLE : S_WAIT;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tx_data       <= 8'h00;
      tx_data_valid <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (state == S_LOAD) begin
        tx_data <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr  <= rd_ptr + (ADDR_W+1)'(1);
      end
      tx_data_valid <= state == S_REQ && tx_data_ready;
      overflow      <= wr_en && full;
    end
`ifdef UART_TX_FIFO_WDOG_EN
  logic [15:0] cnt;
  logic        to_q;
  // tx_ack in the expiry cycle wins: the frame completes normally with no error.
  assign expire      = state == S_WAIT && !tx_ack && cnt == 16'(ACK_TIMEOUT - 1);
  assign timeout_err = to_q;
  always_ff @(posedge clk)
    if (rst) begin
      cnt  <= 16'd0;
      to_q <= 1'b0;
    end else begin
      cnt  <= state == S_WAIT ? cnt + 16'd1 : 16'd0;
      to_q <= expire;
    end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench for uart_tx_fifo against a queue-based reference model
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
`ifdef UART_TX_FIFO_WDOG_EN
  localparam int TO = 300;
  localparam bit WD = 1'b1;
`else
  localparam int TO = 65535;
  localparam bit WD = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full, empty, overflow, tx_data_valid, tx_data_ready, tx_ack, timeout_err;
  logic [4:0] level;
  logic [7:0] tx_data;
  always #5 clk = ~clk;
  uart_tx_fifo #(.ADDR_W(4), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready), .tx_ack(tx_ack), .timeout_err(timeout_err)
  );
  // Reference model: a byte queue plus the issue progress of the byte in hand
  // (0 free, 1 fetching, 2 offered to transmitter, 3 awaiting end of frame).
  logic [7:0] mq[$];
  int         stage = 0;
  int         m_wait = 0;
  logic [7:0] m_data;
  bit         m_valid, m_ovf, m_to, was_full, was_empty;
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      stage = 0; m_wait = 0; m_data = 8'h00; m_valid = 0; m_ovf = 0; m_to = 0;
    end else begin
      was_full  = mq.size() == DEPTH;
      was_empty = mq.size() == 0;
      m_ovf     = wr_en && was_full;
      m_valid   = stage == 2 && tx_data_ready;
      m_to      = 0;
      if (stage == 1) m_data = mq.pop_front();
      if (wr_en && !was_full) mq.push_back(wr_data);
      case (stage)
        0: if (!was_empty) stage = 1;
        1: stage = 2;
        2: if (tx_data_ready) begin stage = 3; m_wait = 0; end
        default:
          if (tx_ack) stage = 0;
`ifdef UART_TX_FIFO_WDOG_EN
          else if (m_wait == TO - 1) begin stage = 0; m_to = 1; end
          else m_wait++;
`else
          else m_wait++;
`endif
      endcase
    end
  end
  int n_cmp = 0, n_bad = 0, n_ovf = 0, n_to = 0, ack_cd = 0, ready_mode = 1;
  bit auto_ack = 0, spur = 0;
  logic [7:0] issued[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // One clock: compare every output with the model, record events, then drive the next inputs.
  task automatic tick(input bit we = 1'b0, input logic [7:0] wd = 8'h00, input bit fa = 1'b0);
    @(negedge clk);
    chk("level", 32'(level), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("tx_data_valid", 32'(tx_data_valid), 32'(m_valid));
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
    if (overflow === 1'b1) n_ovf++;
    if (timeout_err === 1'b1) n_to++;
    if (tx_data_valid === 1'b1) begin
      issued.push_back(tx_data);
      ack_cd = $urandom_range(1, 12);
    end
    wr_en = we;
    wr_data = wd;
    tx_data_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 1;
    tx_ack = fa || (auto_ack && ack_cd == 1) || (spur && $urandom_range(0, 19) == 0);
    if (ack_cd != 0) ack_cd--;
  endtask
  task automatic drain();
    for (int i = 0; i < 4000 && !(mq.size() == 0 && stage == 0); i++) tick();
    chk("drained", 32'(mq.size() == 0 && stage == 0), 32'd1);
  endtask
  initial begin
    wr_en = 0; wr_data = 0; tx_data_ready = 0; tx_ack = 0;
    tick(); tick(); rst = 0;
    tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'h00);
    // single byte: edge N is the one after tick(1, A5)
    ready_mode = 1;
    tick(1, 8'hA5);
    tick(); chk("a5_empty_fall", 32'(empty), 32'd0);
    tick();
    tick(); chk("a5_data", 32'(tx_data), 32'hA5);
    tick(); chk("a5_valid", 32'(tx_data_valid), 32'd1);
    tick(); chk("a5_pulse_end", 32'(tx_data_valid), 32'd0);
    repeat (100) tick();
    chk("a5_one_pulse", 32'(issued.size()), 32'd1);
    chk("a5_no_timeout", 32'(n_to), 32'd0);
    // fill while the byte in flight is never acked
    issued.delete(); n_ovf = 0; ready_mode = 0;
    for (int i = 0; i < 17; i++) begin
      tick(1, 8'(i));
      if (i == 16) begin
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd16);
      end
    end
    repeat (3) tick();
    chk("overflow_once", 32'(n_ovf), 32'd1);
    chk("still_full", 32'(full), 32'd1);
    auto_ack = 1; ready_mode = 2;
    tick(0, 8'h00, 1);
    drain();
    chk("release_count", 32'(issued.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      chk("release_order", i < issued.size() ? 32'(issued[i]) : 32'hx, 32'(i));
    // simultaneous write and pop with three bytes queued
    auto_ack = 0; ready_mode = 1;
    tick(1, 8'h77); repeat (8) tick();
    tick(1, 8'h01); tick(1, 8'h02); tick(1, 8'h03);
    tick(); chk("sim_level3", 32'(level), 32'd3);
    tick(0, 8'h00, 1);
    tick();
    tick(1, 8'h04); chk("sim_level_pre", 32'(level), 32'd3);
    tick();
    chk("sim_level_post", 32'(level), 32'd3);
    chk("sim_data", 32'(tx_data), 32'h01);
    auto_ack = 1;
    drain();
    // ready gating
    auto_ack = 0; ready_mode = 0; issued.delete();
    tick(1, 8'h3C);
    repeat (53) tick();
    chk("gated_no_valid", 32'(issued.size()), 32'd0);
    chk("gated_data", 32'(tx_data), 32'h3C);
    ready_mode = 1;
    tick(); chk("gated_still_low", 32'(tx_data_valid), 32'd0);
    tick(); chk("gated_valid", 32'(tx_data_valid), 32'd1);
    tick(); chk("gated_one_wide", 32'(tx_data_valid), 32'd0);
    // reset mid-operation with five bytes queued
    ready_mode = 0;
    for (int i = 0; i < 5; i++) tick(1, 8'(8'hC0 + i));
    tick(); chk("pre_rst_level", 32'(level), 32'd5);
    rst = 1; tick(); tick(); rst = 0;
    tick();
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(tx_data_valid), 32'd0);
    chk("mid_rst_data", 32'(tx_data), 32'h00);
    // ack withheld: watchdog fires only when compiled in
    ready_mode = 1; n_to = 0;
    tick(1, 8'h5A);
    repeat (WD ? TO + 20 : 150) tick();
    chk("timeout_count", 32'(n_to), WD ? 32'd1 : 32'd0);
    auto_ack = 1;
    tick(0, 8'h00, 1);
    drain();
    // randomized traffic: light load, then heavy load to force fills and overflows
    spur = 1; ready_mode = 2;
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 99) < (i < 1500 ? 30 : 85), 8'($urandom));
    spur = 0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
